// File: rtl/alu_input_mux_a_pkg.sv
// Shared CPU datapath constants: default width and the ALU operand mux
// select encodings (operand A and operand B).
package alu_input_mux_a_pkg;

    // Default datapath width in bits.
    localparam int DATA_W = 32;

    // Operand-A select encodings.
    localparam logic SEL_PC  = 1'b1;
    localparam logic SEL_RS1 = 1'b0;

    // Operand-B select encodings.
    localparam logic SEL_B_RS2 = 1'b0;
    localparam logic SEL_B_IMM = 1'b1;

endpackage

// File: rtl/alu_input_mux_a.sv
// ALU operand-A mux: chooses the program counter or register-file port 1.
// The combinational output is independent of clk/rst. A registered copy of
// the operand and select, plus a sticky "PC was ever selected" flag, are
// provided for downstream pipeline and debug use.
module alu_input_mux_a
    import alu_input_mux_a_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] pc_in,
    input  logic [N-1:0] data1,
    input  logic         A_select,
    output logic [N-1:0] out,
    output logic [N-1:0] out_q,
    output logic         sel_q,
    output logic         pc_used
);

    // The conditional operator merges both inputs bitwise when the select
    // is unknown, so agreeing bits stay known.
    assign out = (A_select == SEL_PC) ? pc_in : data1;

    // Register the operand and select; pc_used latches once PC is sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            sel_q   <= 1'b0;
            pc_used <= 1'b0;
        end else begin
            out_q <= out;
            sel_q <= A_select;
            if (A_select == SEL_PC)
                pc_used <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_input_mux_a.sv
// Self-checking bench for alu_input_mux_a: directed vectors plus randomized
// traffic compared against a simple behavioural model.
module tb_alu_input_mux_a;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic [N-1:0] pc_in;
    logic [N-1:0] data1;
    logic         A_select;
    logic [N-1:0] out;
    logic [N-1:0] out_q;
    logic         sel_q;
    logic         pc_used;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the registered state.
    logic [N-1:0] m_q;
    logic         m_sel;
    logic         m_used;

    alu_input_mux_a #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc_in    (pc_in),
        .data1    (data1),
        .A_select (A_select),
        .out      (out),
        .out_q    (out_q),
        .sel_q    (sel_q),
        .pc_used  (pc_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] pick(input logic s, input logic [N-1:0] p,
                                          input logic [N-1:0] d);
        return s ? p : d;
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if (out_q !== '0) begin errors++; $display("FAIL reset_out_q got %h want 0", out_q); end
        checks++;
        if (sel_q !== 1'b0) begin errors++; $display("FAIL reset_sel_q got %b want 0", sel_q); end
        checks++;
        if (pc_used !== 1'b0) begin errors++; $display("FAIL reset_pc_used got %b want 0", pc_used); end
    endtask

    // Combinational vectors while the registers sit in reset.
    task automatic test_comb_vectors();
        pc_in = 32'h00510193; data1 = 32'h00200113; A_select = 1'b1;
        #1;
        checks++;
        if (out !== 32'h00510193) begin errors++; $display("FAIL vec_pc got %h want 00510193", out); end
        pc_in = 32'h00100093; data1 = 32'h00008067; A_select = 1'b0;
        #1;
        checks++;
        if (out !== 32'h00008067) begin errors++; $display("FAIL vec_rs1 got %h want 00008067", out); end
        // A clock edge during reset must not disturb the registers.
        A_select = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (pc_used !== 1'b0 || out_q !== '0) begin
            errors++; $display("FAIL reset_hold got pc_used=%b out_q=%h want 0/0", pc_used, out_q);
        end
    endtask

    task automatic test_reset_release();
        A_select = 1'b0; data1 = 32'hDEADBEEF; pc_in = 32'h0BADF00D;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_q !== 32'hDEADBEEF) begin errors++; $display("FAIL release_out_q got %h want deadbeef", out_q); end
        checks++;
        if (pc_used !== 1'b0) begin errors++; $display("FAIL release_pc_used got %b want 0", pc_used); end
        checks++;
        if (sel_q !== 1'b0) begin errors++; $display("FAIL release_sel_q got %b want 0", sel_q); end
        m_q = 32'hDEADBEEF; m_sel = 1'b0; m_used = 1'b0;
    endtask

    task automatic test_random(input int iters);
        for (int i = 0; i < iters; i++) begin
            @(negedge clk);
            pc_in    = $urandom;
            data1    = $urandom;
            // Bias toward data1 so pc_used has a chance to stay low a while.
            A_select = ($urandom_range(0, 9) == 0);
            #1;
            checks++;
            if (out !== pick(A_select, pc_in, data1)) begin
                errors++; $display("FAIL rand_out it=%0d got %h want %h", i, out, pick(A_select, pc_in, data1));
            end
            @(posedge clk);
            m_q    = pick(A_select, pc_in, data1);
            m_sel  = A_select;
            m_used = m_used | A_select;
            #1;
            checks++;
            if (out_q !== m_q || sel_q !== m_sel || pc_used !== m_used) begin
                errors++;
                $display("FAIL rand_regs it=%0d got %h/%b/%b want %h/%b/%b",
                         i, out_q, sel_q, pc_used, m_q, m_sel, m_used);
            end
        end
    endtask

    // Select toggles between edges: out follows, only the edge value registers.
    task automatic test_toggle();
        @(negedge clk);
        pc_in = 32'hFFFFFFFF; data1 = 32'h00000000; A_select = 1'b1;
        #1;
        checks++;
        if (out !== 32'hFFFFFFFF) begin errors++; $display("FAIL toggle_1 got %h want ffffffff", out); end
        A_select = 1'b0;
        #1;
        checks++;
        if (out !== 32'h00000000) begin errors++; $display("FAIL toggle_0 got %h want 00000000", out); end
        A_select = 1'b1;
        #1;
        checks++;
        if (out !== 32'hFFFFFFFF) begin errors++; $display("FAIL toggle_1b got %h want ffffffff", out); end
        @(posedge clk); #1;
        checks++;
        if (out_q !== 32'hFFFFFFFF) begin errors++; $display("FAIL toggle_out_q got %h want ffffffff", out_q); end
        checks++;
        if (pc_used !== 1'b1 || sel_q !== 1'b1) begin
            errors++; $display("FAIL toggle_flags got pc_used=%b sel_q=%b want 1/1", pc_used, sel_q);
        end
    endtask

    // Reset mid-cycle clears the registers right away; out is untouched.
    task automatic test_async_reset();
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_q !== '0 || sel_q !== 1'b0 || pc_used !== 1'b0) begin
            errors++; $display("FAIL async_rst got %h/%b/%b want 0/0/0", out_q, sel_q, pc_used);
        end
        checks++;
        if (out !== 32'hFFFFFFFF) begin errors++; $display("FAIL async_rst_out got %h want ffffffff", out); end
    endtask

    task automatic test_x_select();
        pc_in = 32'h12345678; data1 = 32'h12345678; A_select = 1'bx;
        #1;
        checks++;
        if (out !== 32'h12345678) begin errors++; $display("FAIL x_select got %h want 12345678", out); end
    endtask

    initial begin
        rst = 1'b1; pc_in = '0; data1 = '0; A_select = 1'b0;
        m_q = '0; m_sel = 1'b0; m_used = 1'b0;
        test_reset();
        test_comb_vectors();
        test_reset_release();
        test_random(200);
        test_toggle();
        test_async_reset();
        test_x_select();
        test_reset_release();
        test_random(100);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
